// File: rtl/booth_radix4_multiplier_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic [2:0] {OP_ZERO, OP_PM, OP_P2M, OP_NM, OP_N2M} booth_op_t;

  // One iteration per two bits of the (N+2)-bit extended multiplier.
  function automatic int booth_iter(input int n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
interface booth_radix4_multiplier_if #(parameter int N = 8) ();
  logic           start;
  logic           is_signed;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           done;
  logic           busy;

  modport master (output start, is_signed, multiplicand, multiplier,
                  input  product, done, busy);
  modport slave  (input  start, is_signed, multiplicand, multiplier,
                  output product, done, busy);
endinterface

// File: rtl/booth_radix4_multiplier_recoder.sv
// Radix-4 Booth recoder: triplet {q1, q0, q-1} to the partial-product operation.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet_i,
  output booth_op_t  op_o
);

  always_comb begin
    op_o = OP_ZERO;
    case (triplet_i)
      3'b001, 3'b010: op_o = OP_PM;
      3'b011:         op_o = OP_P2M;
      3'b100:         op_o = OP_N2M;
      3'b101, 3'b110: op_o = OP_NM;
      default:        op_o = OP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// retiring two multiplier bits per CALC cycle.
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input logic                     clock,
  input logic                     reset,
  booth_radix4_multiplier_if.slave bus
);

  localparam int W    = N + 2;
  localparam int ITER = booth_iter(N);
  localparam int CW   = $clog2(ITER + 1);

  state_t                state_q;
  logic signed [W:0]     a_q, a_d;
  logic        [W-1:0]   qx_q, qx_d;
  logic                  qm1_q, qm1_d;
  logic signed [W-1:0]   m_q;
  logic        [CW-1:0]  cnt_q;
  logic        [2*N-1:0] product_q, product_d;
  logic                  done_q;
  logic                  busy_q;

  booth_op_t             op;
  logic signed [W:0]     m_ext, m_x2, addend, a_sum;
  logic signed [2*W+1:0] acc_cat, acc_sh;

  // Two guard bits let unsigned 2^N-1 stay positive after extension.
  function automatic logic signed [W-1:0] extend(input logic [N-1:0] v, input logic sgn);
    return sgn ? {{2{v[N-1]}}, v} : {2'b00, v};
  endfunction

  booth_r4_recoder u_recoder (
    .triplet_i ({qx_q[1:0], qm1_q}),
    .op_o      (op)
  );

  always_comb begin
    m_ext  = {m_q[W-1], m_q};
    m_x2   = {m_q, 1'b0};
    addend = '0;
    case (op)
      OP_PM:   addend = m_ext;
      OP_P2M:  addend = m_x2;
      OP_NM:   addend = -m_ext;
      OP_N2M:  addend = -m_x2;
      default: addend = '0;
    endcase
    a_sum     = a_q + addend;
    acc_cat   = {a_sum, qx_q, qm1_q};
    acc_sh    = acc_cat >>> 2;
    a_d       = acc_sh[2*W+1:W+1];
    qx_d      = acc_sh[W:1];
    qm1_d     = acc_sh[0];
    product_d = {a_q[N-3:0], qx_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      qx_q      <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= bus.start;
          if (bus.start) begin
            m_q     <= extend(bus.multiplicand, bus.is_signed);
            qx_q    <= extend(bus.multiplier, bus.is_signed);
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          busy_q <= 1'b1;
          a_q    <= a_d;
          qx_q   <= qx_d;
          qm1_q  <= qm1_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) state_q <= DONE;
        end
        DONE: begin
          // busy stays up through the done cycle, which is already back in IDLE.
          busy_q    <= 1'b1;
          product_q <= product_d;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule
